// File: rtl/result_bus_arbiter.sv
// ----------------------------------------------------------------------------
// result_bus_arbiter
//
// Shares the single reorder-buffer write-back port between the ALU reservation
// station and the load & store buffer. Each source pushes completed results
// into its own small FIFO. A round-robin scheduler drains one entry per cycle
// onto a registered result bus. That bus drives the ROB update inputs and the
// RS/LSB operand-forwarding snoop. A ROB clear flushes everything still queued.
//
// Parameters
//   ROB_WIDTH    width of a ROB index
//   QUEUE_WIDTH  log2 of the per-source FIFO depth (must be >= 1, depth >= 2)
//
// Ports
//   clockIn      in   1          clock, all state on rising edge
//   resetIn      in   1          asynchronous, active-low reset
//   clear        in   1          ROB mispredict flush, sampled on clock edge
//   aluValid     in   1          ALU result offered
//   aluRobIndex  in   ROB_WIDTH  ROB entry of ALU result
//   aluValue     in   32         ALU result value
//   aluReady     out  1          ALU FIFO can accept this cycle
//   lsbValid     in   1          load/store result offered
//   lsbRobIndex  in   ROB_WIDTH  ROB entry of LSB result
//   lsbValue     in   32         LSB result value
//   lsbReady     out  1          LSB FIFO can accept this cycle
//   busValid     out  1          result bus carries a result this cycle
//   busRobIndex  out  ROB_WIDTH  ROB entry being completed
//   busValue     out  32         completed value
//   busSrc       out  1          0 = ALU, 1 = LSB
// ----------------------------------------------------------------------------
module result_bus_arbiter #(
   parameter int ROB_WIDTH   = 4,
   parameter int QUEUE_WIDTH = 1
) (
   input  logic                 clockIn,
   input  logic                 resetIn,
   input  logic                 clear,

   input  logic                 aluValid,
   input  logic [ROB_WIDTH-1:0] aluRobIndex,
   input  logic [31:0]          aluValue,
   output logic                 aluReady,

   input  logic                 lsbValid,
   input  logic [ROB_WIDTH-1:0] lsbRobIndex,
   input  logic [31:0]          lsbValue,
   output logic                 lsbReady,

   output logic                 busValid,
   output logic [ROB_WIDTH-1:0] busRobIndex,
   output logic [31:0]          busValue,
   output logic                 busSrc
);

   localparam int DEPTH       = 2 ** QUEUE_WIDTH;
   localparam int ENTRY_WIDTH = ROB_WIDTH + 32;
   localparam int NUM_SRC     = 2;

   // The count is one bit wider than the pointers so that "full" is distinct
   // from "empty" when head == tail.
   localparam logic [QUEUE_WIDTH:0]   FULL_COUNT = {1'b1, {QUEUE_WIDTH{1'b0}}};
   localparam logic [QUEUE_WIDTH-1:0] PTR_ONE    = QUEUE_WIDTH'(1);
   localparam logic [QUEUE_WIDTH:0]   CNT_ONE    = (QUEUE_WIDTH + 1)'(1);

   // Source index 0 is the ALU and index 1 is the LSB. This matches the encoding of busSrc.
   logic [NUM_SRC-1:0]     pushValid;
   logic [NUM_SRC-1:0]     srcReady;
   logic [NUM_SRC-1:0]     pushAccept;
   logic [NUM_SRC-1:0]     nonEmpty;
   logic [NUM_SRC-1:0]     popGrant;
   logic [ENTRY_WIDTH-1:0] pushEntry [NUM_SRC];
   logic [ENTRY_WIDTH-1:0] headEntry [NUM_SRC];

   // Arbitration and result-bus state
   logic                 grantValid;
   logic                 grantSrc;
   logic                 lastGrant_reg,   lastGrant_next;
   logic                 busValid_reg,    busValid_next;
   logic [ROB_WIDTH-1:0] busRobIndex_reg, busRobIndex_next;
   logic [31:0]          busValue_reg,    busValue_next;
   logic                 busSrc_reg,      busSrc_next;

   assign pushValid    = {lsbValid, aluValid};
   assign pushEntry[0] = {aluRobIndex, aluValue};
   assign pushEntry[1] = {lsbRobIndex, lsbValue};

   assign aluReady = srcReady[0];
   assign lsbReady = srcReady[1];

   // -------------------------------------------------------------------------
   // Per-source result FIFOs
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gen_fifo
         logic [ENTRY_WIDTH-1:0] mem [DEPTH];
         logic [QUEUE_WIDTH-1:0] head_reg,  head_next;
         logic [QUEUE_WIDTH-1:0] tail_reg,  tail_next;
         logic [QUEUE_WIDTH:0]   count_reg, count_next;

         // Ready depends only on the registered count. A pop in the same cycle
         // does not open a slot for a push in that cycle. This keeps the ready
         // path free of the arbiter logic.
         assign srcReady[gi]   = resetIn && (count_reg != FULL_COUNT);
         // During a flush, pushes are discarded together with the queued entries.
         assign pushAccept[gi] = pushValid[gi] && srcReady[gi] && !clear;
         assign nonEmpty[gi]   = (count_reg != '0);
         // The head is read directly from the array. The registered read stage
         // is the result-bus register that this value is loaded into.
         assign headEntry[gi]  = mem[head_reg];

         always_comb begin
            head_next  = head_reg;
            tail_next  = tail_reg;
            count_next = count_reg;
            if (clear) begin
               head_next  = '0;
               tail_next  = '0;
               count_next = '0;
            end else begin
               if (pushAccept[gi]) begin
                  tail_next = tail_reg + PTR_ONE;
               end
               if (popGrant[gi]) begin
                  head_next = head_reg + PTR_ONE;
               end
               // A push and a pop in the same cycle cancel out. This is also valid
               // when the FIFO is full.
               case ({pushAccept[gi], popGrant[gi]})
                  2'b10:   count_next = count_reg + CNT_ONE;
                  2'b01:   count_next = count_reg - CNT_ONE;
                  default: count_next = count_reg;
               endcase
            end
         end

         always_ff @(posedge clockIn or negedge resetIn) begin
            if (!resetIn) begin
               head_reg  <= '0;
               tail_reg  <= '0;
               count_reg <= '0;
            end else begin
               head_reg  <= head_next;
               tail_reg  <= tail_next;
               count_reg <= count_next;
            end
         end

         // The storage has no reset. Any stale contents are hidden by the pointers and count.
         always_ff @(posedge clockIn) begin
            if (pushAccept[gi]) begin
               mem[tail_reg] <= pushEntry[gi];
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Round-robin scheduler and result-bus next state
   // -------------------------------------------------------------------------
   always_comb begin
      grantValid = |nonEmpty;
      grantSrc   = 1'b0;
      // When both sources have work, grant the one that did not win last.
      // Otherwise grant whichever source is non-empty.
      if (nonEmpty[0] && nonEmpty[1]) begin
         grantSrc = ~lastGrant_reg;
      end else if (nonEmpty[1]) begin
         grantSrc = 1'b1;
      end

      popGrant = '0;
      if (grantValid && !clear) begin
         popGrant[grantSrc] = 1'b1;
      end

      // When no result is granted, busValid falls and the data fields keep their old values.
      busValid_next    = 1'b0;
      busRobIndex_next = busRobIndex_reg;
      busValue_next    = busValue_reg;
      busSrc_next      = busSrc_reg;
      lastGrant_next   = lastGrant_reg;

      if (grantValid && !clear) begin
         busValid_next                     = 1'b1;
         {busRobIndex_next, busValue_next} = headEntry[grantSrc];
         busSrc_next                       = grantSrc;
         lastGrant_next                    = grantSrc;
      end
   end

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         busValid_reg    <= 1'b0;
         busRobIndex_reg <= '0;
         busValue_reg    <= '0;
         busSrc_reg      <= 1'b0;
         // The reset value points at the LSB, so the ALU wins the first tie.
         lastGrant_reg   <= 1'b1;
      end else begin
         busValid_reg    <= busValid_next;
         busRobIndex_reg <= busRobIndex_next;
         busValue_reg    <= busValue_next;
         busSrc_reg      <= busSrc_next;
         lastGrant_reg   <= lastGrant_next;
      end
   end

   assign busValid    = busValid_reg;
   assign busRobIndex = busRobIndex_reg;
   assign busValue    = busValue_reg;
   assign busSrc      = busSrc_reg;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for result_bus_arbiter (ROB_WIDTH=4, QUEUE_WIDTH=1, depth 2).
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// at that point, or on the falling edge by the scoreboard monitor.
// ----------------------------------------------------------------------------
module tb_result_bus_arbiter;

   logic        clockIn = 1'b0;
   logic        resetIn = 1'b0;
   logic        clear = 1'b0;
   logic        aluValid = 1'b0;
   logic [3:0]  aluRobIndex = '0;
   logic [31:0] aluValue = '0;
   logic        aluReady;
   logic        lsbValid = 1'b0;
   logic [3:0]  lsbRobIndex = '0;
   logic [31:0] lsbValue = '0;
   logic        lsbReady;
   logic        busValid;
   logic [3:0]  busRobIndex;
   logic [31:0] busValue;
   logic        busSrc;

   result_bus_arbiter #(.ROB_WIDTH(4), .QUEUE_WIDTH(1)) dut (
      .clockIn     (clockIn),
      .resetIn     (resetIn),
      .clear       (clear),
      .aluValid    (aluValid),
      .aluRobIndex (aluRobIndex),
      .aluValue    (aluValue),
      .aluReady    (aluReady),
      .lsbValid    (lsbValid),
      .lsbRobIndex (lsbRobIndex),
      .lsbValue    (lsbValue),
      .lsbReady    (lsbReady),
      .busValid    (busValid),
      .busRobIndex (busRobIndex),
      .busValue    (busValue),
      .busSrc      (busSrc)
   );

   always #5 clockIn = ~clockIn;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] val;
   } entry_t;

   typedef struct packed {
      logic       src;
      logic [3:0] idx;
   } logrec_t;

   entry_t  aluQ[$];
   entry_t  lsbQ[$];
   logrec_t busLog[$];
   int      throttleSeen = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic cycle();
      @(posedge clockIn);
      #1;
   endtask

   // Scoreboard monitor. First, the result on the bus is matched against the
   // oldest expected entry of its source. Then the effect of the coming edge
   // is modelled: a flush or reset empties the queues, and otherwise each
   // accepted push is queued.
   always @(negedge clockIn) begin
      entry_t e;
      if (busValid === 1'b1) begin
         busLog.push_back(logrec_t'({busSrc, busRobIndex}));
         if ((busSrc == 1'b0 && aluQ.size() == 0) || (busSrc == 1'b1 && lsbQ.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: bus src %0d idx %0d value %0h, none queued for that source",
                     busSrc, busRobIndex, busValue);
         end else begin
            if (busSrc) e = lsbQ.pop_front();
            else        e = aluQ.pop_front();
            check("sb_result", {busRobIndex, busValue}, e);
            $display("bus: src=%0d idx=%0d value=%08h", busSrc, busRobIndex, busValue);
         end
      end
      if (!resetIn || clear) begin
         aluQ.delete();
         lsbQ.delete();
      end else begin
         if (aluValid && aluReady) aluQ.push_back(entry_t'({aluRobIndex, aluValue}));
         if (lsbValid && lsbReady) lsbQ.push_back(entry_t'({lsbRobIndex, lsbValue}));
      end
      if (resetIn && (!aluReady || !lsbReady)) throttleSeen++;
   end

   // Table of one-cycle vectors. Each row drives its inputs for one cycle and
   // gives the outputs expected in that cycle, which come from earlier rows.
   typedef struct {
      logic        aV;
      logic [3:0]  aI;
      logic [31:0] aD;
      logic        lV;
      logic [3:0]  lI;
      logic [31:0] lD;
      logic        clr;
      logic        eV;
      logic [3:0]  eI;
      logic [31:0] eD;
      logic        eS;
      logic        eAR;
      logic        eLR;
   } vec_t;

   localparam int NVEC = 17;
   vec_t tbl [NVEC];

   task automatic doReset();
      resetIn  = 1'b0;
      aluValid = 1'b0;
      lsbValid = 1'b0;
      clear    = 1'b0;
      cycle();
      cycle();
      check("reset_state", {busValid, busRobIndex, busValue, busSrc, aluReady, lsbReady}, 40'h0);
      resetIn = 1'b1;
      #1;
      check("reset_release_ready", {aluReady, lsbReady}, 2'b11);
      cycle();
   endtask

   initial begin
      logrec_t expLog[$];
      int      aN;
      int      lN;
      logic    accA;
      logic    accL;

      //           aV    aI     aD            lV    lI      lD            clr   eV    eI     eD            eS    eAR   eLR
      tbl[0]  = '{1'b1, 4'd3,  32'h1234,     1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 1'b1};
      tbl[1]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 1'b1};
      tbl[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd3,  32'h1234,     1'b0, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 4'd1,  32'hA1,       1'b1, 4'd9,  32'hB9,       1'b0, 1'b0, 4'd3,  32'h1234,     1'b0, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd3,  32'h1234,     1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd9,  32'hB9,       1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd1,  32'hA1,       1'b0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd1,  32'hA1,       1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 4'd4,  32'h44,       1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd1,  32'hA1,       1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 4'd5,  32'h55,       1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd1,  32'hA1,       1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 4'd6,  32'h66,       1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd4,  32'h44,       1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd5,  32'h55,       1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd6,  32'h66,       1'b0, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 4'd7,  32'h77,       1'b1, 4'd10, 32'hAA,       1'b0, 1'b0, 4'd6,  32'h66,       1'b0, 1'b1, 1'b1};
      tbl[14] = '{1'b1, 4'd8,  32'h88,       1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 4'd6,  32'h66,       1'b0, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd6,  32'h66,       1'b0, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd6,  32'h66,       1'b0, 1'b1, 1'b1};

      doReset();

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < NVEC; i++) begin
         aluValid    = tbl[i].aV;
         aluRobIndex = tbl[i].aI;
         aluValue    = tbl[i].aD;
         lsbValid    = tbl[i].lV;
         lsbRobIndex = tbl[i].lI;
         lsbValue    = tbl[i].lD;
         clear       = tbl[i].clr;
         check($sformatf("vec%0d", i),
               {busValid, busRobIndex, busValue, busSrc, aluReady, lsbReady},
               {tbl[i].eV, tbl[i].eI, tbl[i].eD, tbl[i].eS, tbl[i].eAR, tbl[i].eLR});
         $display("vec%0d: busValid=%0d idx=%0d value=%08h src=%0d aluReady=%0d lsbReady=%0d",
                  i, busValid, busRobIndex, busValue, busSrc, aluReady, lsbReady);
         cycle();
      end
      aluValid = 1'b0;
      lsbValid = 1'b0;
      clear    = 1'b0;
      cycle();

      // ---------------- saturated: both sources push every cycle ----------------
      doReset();
      busLog.delete();
      throttleSeen = 0;
      aN = 0;
      lN = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (aN == 8 && lN == 8 && aluQ.size() == 0 && lsbQ.size() == 0) break;
         aluValid    = (aN < 8);
         aluRobIndex = aN[3:0];
         aluValue    = 32'hA000 + aN;
         lsbValid    = (lN < 8);
         lsbRobIndex = 4'(8 + lN);
         lsbValue    = 32'hB000 + lN;
         @(negedge clockIn);
         accA = aluValid && aluReady;
         accL = lsbValid && lsbReady;
         @(posedge clockIn);
         #1;
         if (accA) aN++;
         if (accL) lN++;
      end
      aluValid = 1'b0;
      lsbValid = 1'b0;
      repeat (3) cycle();
      check("sat_all_accepted", {aN[7:0], lN[7:0]}, {8'd8, 8'd8});
      check("sat_throttled", (throttleSeen > 0), 1'b1);
      expLog.delete();
      for (int i = 0; i < 8; i++) begin
         expLog.push_back(logrec_t'({1'b0, 4'(i)}));
         expLog.push_back(logrec_t'({1'b1, 4'(8 + i)}));
      end
      check("sat_count", busLog.size(), 16);
      for (int i = 0; i < 16 && i < busLog.size(); i++) begin
         check($sformatf("sat_order%0d", i), busLog[i], expLog[i]);
      end

      // ---------------- LSB FIFO fills and throttles while ALU competes ----------------
      doReset();
      busLog.delete();
      aluValid = 1'b1; aluRobIndex = 4'd1; aluValue = 32'h100;
      lsbValid = 1'b1; lsbRobIndex = 4'd5; lsbValue = 32'h500;
      cycle();
      aluRobIndex = 4'd2; aluValue = 32'h200;
      lsbRobIndex = 4'd6; lsbValue = 32'h600;
      cycle();
      check("fill_lsb_full", lsbReady, 1'b0);
      aluRobIndex = 4'd3; aluValue = 32'h300;
      lsbRobIndex = 4'd7; lsbValue = 32'h700;
      cycle();
      check("fill_lsb_after_pop", lsbReady, 1'b1);
      check("fill_bus_5", {busValid, busSrc, busRobIndex}, {1'b1, 1'b1, 4'd5});
      aluValid = 1'b0;
      cycle();
      check("fill_lsb_full_again", lsbReady, 1'b0);
      check("fill_bus_alu2", {busValid, busSrc, busRobIndex}, {1'b1, 1'b0, 4'd2});
      lsbValid = 1'b0;
      repeat (6) cycle();
      expLog.delete();
      expLog.push_back(logrec_t'({1'b0, 4'd1}));
      expLog.push_back(logrec_t'({1'b1, 4'd5}));
      expLog.push_back(logrec_t'({1'b0, 4'd2}));
      expLog.push_back(logrec_t'({1'b1, 4'd6}));
      expLog.push_back(logrec_t'({1'b0, 4'd3}));
      expLog.push_back(logrec_t'({1'b1, 4'd7}));
      check("fill_count", busLog.size(), 6);
      for (int i = 0; i < 6 && i < busLog.size(); i++) begin
         check($sformatf("fill_order%0d", i), busLog[i], expLog[i]);
      end

      // ---------------- clear with 2 ALU + 1 LSB queued ----------------
      // A single ALU result first, so that the following tie goes to the LSB.
      aluValid = 1'b1; aluRobIndex = 4'd4; aluValue = 32'h400;
      cycle();
      aluValid = 1'b0;
      repeat (3) cycle();
      busLog.delete();
      aluValid = 1'b1; aluRobIndex = 4'd10; aluValue = 32'hC10;
      lsbValid = 1'b1; lsbRobIndex = 4'd11; lsbValue = 32'hC11;
      cycle();
      aluRobIndex = 4'd12; aluValue = 32'hC12;
      lsbRobIndex = 4'd13; lsbValue = 32'hC13;
      cycle();
      check("clr_pre_bus", {busValid, busSrc, busRobIndex}, {1'b1, 1'b1, 4'd11});
      check("clr_pre_alu_full", aluReady, 1'b0);
      aluValid = 1'b0;
      lsbRobIndex = 4'd14; lsbValue = 32'hC14;
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      lsbValid = 1'b0;
      check("clr_bus_idle", busValid, 1'b0);
      check("clr_ready", {aluReady, lsbReady}, 2'b11);
      repeat (5) cycle();
      check("clr_nothing_leaked", busLog.size(), 1);

      // ---------------- asynchronous reset while busy ----------------
      aluValid = 1'b1; aluRobIndex = 4'd2; aluValue = 32'hD02;
      lsbValid = 1'b1; lsbRobIndex = 4'd9; lsbValue = 32'hD09;
      repeat (3) cycle();
      check("arst_pre_busy", busValid, 1'b1);
      #2;
      resetIn = 1'b0;
      #1;
      check("arst_bus_drop", busValid, 1'b0);
      check("arst_ready_low", {aluReady, lsbReady}, 2'b00);
      aluValid = 1'b0;
      lsbValid = 1'b0;
      @(negedge clockIn);
      #2;
      resetIn = 1'b1;
      busLog.delete();
      cycle();
      repeat (5) cycle();
      check("arst_idle_after", {busValid, 8'(busLog.size())}, 9'h0);
      check("arst_ready_back", {aluReady, lsbReady}, 2'b11);
      check("sb_drained", {8'(aluQ.size()), 8'(lsbQ.size())}, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, limit 200000 required");
      $fatal(1, "timeout");
   end

endmodule
